// File: rtl/rs232out_pkg.sv
// Shared serial-frame definitions for the RS-232 transmit and receive paths.
package rs232out_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;
  // Bit timer wide enough for periods up to 2**17-1 clocks.
  localparam int TIMER_W    = 17;
endpackage

// File: rtl/rs232out_fifo.sv
// Circular byte FIFO feeding the transmitter; pushes while full are dropped.
module rs232out_fifo #(
  parameter int depth_log2 = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);
  localparam int DEPTH = 2 ** depth_log2;

  logic [7:0]            mem [DEPTH];
  logic [depth_log2-1:0] rd_ptr, wr_ptr;
  logic [depth_log2:0]   count;
  logic                  do_push, do_pop;

  assign full     = (count == (depth_log2 + 1)'(DEPTH));
  assign empty    = (count == '0);
  // Full blocks a push even when a pop frees a slot on the same edge.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/rs232out.sv
// 8N1 serial transmitter: byte FIFO in front of a bit-timer driven frame FSM.
module rs232out
  import rs232out_pkg::*;
#(
  parameter int bps        = 57_600,
  parameter int frequency  = 25_000_000,
  parameter int period     = (frequency + bps / 2) / bps,
  parameter int depth_log2 = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       transmit,
  input  logic [7:0] transmit_data,
  output logic       ready,
  output logic       busy,
  output logic       serial_out
);
  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(period - 1);

  tx_state_t            state, state_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, fifo_dout;
  logic [3:0]           bit_idx, bit_idx_n;
  logic                 line_n, launch, pop, full, empty;

  rs232out_fifo #(.depth_log2(depth_log2)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (transmit),
    .push_data (transmit_data),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (full),
    .empty     (empty)
  );

  assign ready = !full;
  assign busy  = !empty || (state != IDLE);

  // bit_idx walks the whole frame: 0 = start, 1..8 = data, 9 = stop.
  always_comb begin
    state_n   = state;
    timer_n   = (timer == '0) ? timer : timer - 1'b1;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    line_n    = serial_out;
    launch    = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: launch = !empty;
      START, DATA: begin
        if (timer == '0) begin
          timer_n   = RELOAD;
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 4'(FRAME_BITS - 2)) begin
            state_n = STOP;
            line_n  = 1'b1;
          end else begin
            state_n = DATA;
            line_n  = shreg[0];
            shreg_n = shreg >> 1;
          end
        end
      end
      STOP: begin
        if (timer == '0) begin
          if (!empty) begin
            launch = 1'b1;
          end else begin
            state_n = IDLE;
            line_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Chaining from STOP straight into START gives gapless back-to-back frames.
    if (launch) begin
      pop       = 1'b1;
      state_n   = START;
      timer_n   = RELOAD;
      shreg_n   = fifo_dout;
      bit_idx_n = '0;
      line_n    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      timer      <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      shreg      <= shreg_n;
      bit_idx    <= bit_idx_n;
      serial_out <= line_n;
    end
  end
endmodule

// File: tb/tb_rs232out.sv
// Bench for rs232out: line-level reference model, serial receiver and directed/random stimulus.
module tb_rs232out;
  localparam int P     = 10;
  localparam int DEPTH = 16;
  localparam int PD    = 434;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n, transmit, transmit_d;
  logic [7:0] transmit_data, data_d;
  logic       ready, busy, serial_out;
  logic       ready_d, busy_d, serial_d;

  rs232out #(.bps(100_000), .frequency(1_000_000), .depth_log2(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .transmit      (transmit),
    .transmit_data (transmit_data),
    .ready         (ready),
    .busy          (busy),
    .serial_out    (serial_out)
  );

  rs232out dut_def (
    .clock         (clock),
    .reset_n       (reset_n),
    .transmit      (transmit_d),
    .transmit_data (data_d),
    .ready         (ready_d),
    .busy          (busy_d),
    .serial_out    (serial_d)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: waiting bytes, plus the frame on the wire and its cycle offset.
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  logic [7:0] cur = 8'h00;
  bit         active = 1'b0;
  int         t = 0;
  int         n_acc = 0;
  int         rst_epoch = 0;

  always @(posedge clock) begin
    bit acc;
    if (!reset_n) begin
      mq.delete();
      active = 1'b0;
      t = 0;
      rst_epoch++;
    end else begin
      acc = transmit && (mq.size() < DEPTH);
      if (active) begin
        t++;
        if (t == 10 * P) active = 1'b0;
      end
      if (!active && mq.size() != 0) begin
        cur = mq.pop_front();
        active = 1'b1;
        t = 0;
        sent.push_back(cur);
      end
      if (acc) begin
        mq.push_back(transmit_data);
        n_acc++;
      end
    end
  end

  function automatic logic exp_line();
    int k;
    if (!active) return 1'b1;
    k = t / P;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[k-1];
    return 1'b1;
  endfunction

  // Per-cycle compare plus a mid-bit sampling receiver checked against bytes launched.
  int         rx_epoch = 0;
  int         rx_idx = 0;
  int         rx_cnt = 0;
  bit         rx_on = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge clock) begin
    if (chk_en) begin
      check("line", serial_out, exp_line());
      check("ready", ready, mq.size() < DEPTH);
      check("busy", busy, active || mq.size() != 0);
      if (rx_epoch != rst_epoch) begin
        rx_epoch = rst_epoch;
        rx_on = 1'b0;
        rx_idx = sent.size();
      end else if (rx_on) begin
        rx_cnt++;
        if (rx_cnt >= P && rx_cnt < 9 * P && rx_cnt % P == P / 2)
          rx_byte[rx_cnt/P-1] = serial_out;
        if (rx_cnt == 9 * P + P / 2) begin
          check("rx stop", serial_out, 1'b1);
          if (rx_idx < sent.size()) check("rx byte", rx_byte, sent[rx_idx]);
          else check("rx extra frame", 0, 1);
          rx_idx++;
          rx_on = 1'b0;
        end
      end else if (serial_out == 1'b0) begin
        rx_on = 1'b1;
        rx_cnt = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while ((busy || mq.size() != 0) && n < limit) begin
      cyc();
      n++;
    end
    check(name, n < limit, 1'b1);
    repeat (3) cyc();
  endtask

  logic [9:0] a5f = 10'b1101001010;
  logic [9:0] f41 = 10'b1010000010;
  logic [7:0] tri_b [3] = '{8'h00, 8'hFF, 8'h55};
  int a0, n;

  initial begin
    reset_n = 1'b0; transmit = 1'b0; transmit_data = 8'h00;
    transmit_d = 1'b0; data_d = 8'h00;
    repeat (3) cyc();
    check("reset line", serial_out, 1'b1);
    check("reset ready", ready, 1'b1);
    check("reset busy", busy, 1'b0);
    reset_n = 1'b1;
    chk_en = 1'b1;
    cyc();

    // Single 0xA5 frame with hand-derived bit values.
    transmit = 1'b1; transmit_data = 8'hA5; cyc(); transmit = 1'b0;
    for (int c = 1; c <= 101; c++) begin
      cyc();
      if (c % 10 == 5) check("a5 bit", serial_out, a5f[c/10]);
      if (c == 10)  check("a5 start last", serial_out, 1'b0);
      if (c == 11)  check("a5 b0 first", serial_out, 1'b1);
      if (c == 100) check("a5 busy held", busy, 1'b1);
      if (c == 101) check("a5 busy fall", busy, 1'b0);
    end
    repeat (3) cyc();

    // Three consecutive writes: gapless frames.
    a0 = rx_idx;
    for (int i = 0; i < 3; i++) begin
      transmit = 1'b1; transmit_data = tri_b[i]; cyc();
    end
    transmit = 1'b0;
    for (int c = 3; c <= 301; c++) begin
      cyc();
      if (c == 11)  check("tri b0 of 00", serial_out, 1'b0);
      if (c == 100) check("tri stop1", serial_out, 1'b1);
      if (c == 101) check("tri start2", serial_out, 1'b0);
      if (c == 111) check("tri b0 of ff", serial_out, 1'b1);
      if (c == 201) check("tri start3", serial_out, 1'b0);
      if (c == 300) check("tri busy held", busy, 1'b1);
      if (c == 301) check("tri busy fall", busy, 1'b0);
    end
    repeat (10) cyc();
    check("tri rx count", rx_idx - a0, 3);

    // 17 writes held high fill the FIFO; then keep pushing while full.
    a0 = n_acc;
    transmit = 1'b1;
    for (int i = 0; i < 17; i++) begin transmit_data = 8'($urandom); cyc(); end
    check("fill accepted", n_acc - a0, 17);
    check("full ready", ready, 1'b0);
    a0 = n_acc;
    for (int i = 0; i < 120; i++) begin transmit_data = 8'($urandom); cyc(); end
    transmit = 1'b0;
    check("full hold accepted", n_acc - a0, 1);
    wait_idle("fill drain", 2500);

    // Push exactly on the pop edge with 15 waiting.
    transmit = 1'b1;
    for (int i = 0; i < 16; i++) begin transmit_data = 8'($urandom); cyc(); end
    transmit = 1'b0;
    check("pre pop depth", mq.size(), 15);
    n = 0;
    while (!(active && t == 10 * P - 1 && mq.size() == 15) && n < 300) begin cyc(); n++; end
    check("pop edge reached", n < 300, 1'b1);
    transmit = 1'b1; transmit_data = 8'h3C; cyc(); transmit = 1'b0;
    check("pop push depth", mq.size(), 15);
    check("pop push ready", ready, 1'b1);
    wait_idle("pop push drain", 2500);

    // Reset mid-frame with three bytes queued.
    transmit = 1'b1;
    for (int i = 0; i < 4; i++) begin transmit_data = 8'($urandom); cyc(); end
    transmit = 1'b0;
    check("queued before abort", mq.size(), 3);
    n = 0;
    while (!(active && t == 44) && n < 200) begin cyc(); n++; end
    check("abort point reached", n < 200, 1'b1);
    reset_n = 1'b0; cyc();
    check("abort line", serial_out, 1'b1);
    check("abort busy", busy, 1'b0);
    check("abort ready", ready, 1'b1);
    reset_n = 1'b1;
    repeat (300) cyc();
    check("abort quiet line", serial_out, 1'b1);
    check("abort quiet busy", busy, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      transmit = ($urandom_range(0, 11) == 0);
      transmit_data = 8'($urandom);
      reset_n = ($urandom_range(0, 1499) != 0);
      cyc();
    end
    transmit = 1'b0; reset_n = 1'b1;
    wait_idle("random drain", 3000);
    repeat (10) cyc();
    check("rx all frames", rx_idx, sent.size());

    // Default parameters: 434-cycle bits, 0x41.
    transmit_d = 1'b1; data_d = 8'h41; cyc(); transmit_d = 1'b0;
    for (int c = 1; c <= 10 * PD + 1; c++) begin
      cyc();
      if (c <= 10 * PD && ((c - 1) % PD == 0 || c % PD == 0))
        check("def bit edge", serial_d, f41[(c-1)/PD]);
      if (c == 10 * PD)     check("def busy held", busy_d, 1'b1);
      if (c == 10 * PD + 1) check("def busy fall", busy_d, 1'b0);
      if (c == 10 * PD + 1) check("def idle line", serial_d, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
